// File: rtl/keyin_pkg.sv
// keyin_pkg: shared constants for the keyin input peripheral.
//   - register addresses on the 4-bit device bus
//   - CTRL register bit positions
//   - debounce sample history length
//   - edge-event helper used by the top level
package keyin_pkg;

  localparam logic [3:0] KEYIN_STATE     = 4'h0;
  localparam logic [3:0] KEYIN_FLAGS     = 4'h1;
  localparam logic [3:0] KEYIN_MASK      = 4'h2;
  localparam logic [3:0] KEYIN_EDGE      = 4'h3;
  localparam logic [3:0] KEYIN_CTRL      = 4'h4;
  localparam logic [3:0] KEYIN_PERIOD_HI = 4'h5;
  localparam logic [3:0] KEYIN_PERIOD_LO = 4'h6;

  localparam int KEYIN_CTRL_IRQ = 7;
  localparam int KEYIN_CTRL_IEN = 6;

  localparam int KEYIN_HIST_LEN = 4;

  // Per-bit event: rising when sel=0, falling when sel=1.
  function automatic logic [7:0] keyin_edge_events(input logic [7:0] cur,
                                                   input logic [7:0] prev,
                                                   input logic [7:0] sel);
    return (cur & ~prev & ~sel) | (~cur & prev & sel);
  endfunction

endpackage

// File: rtl/keyin_debounce.sv
// keyin_debounce: one key line through a SYNC_STAGES-deep synchronizer and,
// when KEYIN_DEBOUNCE_EN is defined, a 4-sample history filter clocked by the
// shared tick. Without the macro the output is the synchronizer output,
// registered once.
// Ports:
//   clk_in   clock
//   rst      synchronous active-high reset
//   i_key    asynchronous key level
//   i_tick   shared one-cycle sample strobe
//   o_state  debounced (registered) level
module keyin_debounce
  import keyin_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_key,
  input  logic i_tick,
  output logic o_state
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_state;

  // Synchronizer shift chain.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef KEYIN_DEBOUNCE_EN
  logic [KEYIN_HIST_LEN-1:0] r_hist;
  logic [KEYIN_HIST_LEN-1:0] w_hist_next;

  assign w_hist_next = {r_hist[KEYIN_HIST_LEN-2:0], w_sync};

  // Sample on tick; the level is accepted on the same tick the history
  // becomes uniform, otherwise it holds.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_hist  <= {KEYIN_HIST_LEN{1'b0}};
      r_state <= 1'b0;
    end else if (i_tick) begin
      r_hist <= w_hist_next;
      if (&w_hist_next) begin
        r_state <= 1'b1;
      end else if (~|w_hist_next) begin
        r_state <= 1'b0;
      end
    end
  end
`else
  logic w_unused_tick;
  assign w_unused_tick = i_tick;

  // Filter absent: follow the synchronizer one cycle later.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= 1'b0;
    end else begin
      r_state <= w_sync;
    end
  end
`endif

  assign o_state = r_state;

endmodule

// File: rtl/keyin.sv
// keyin: memory-mapped 8-line key/switch input peripheral.
// Synchronizes and debounces keys, latches edge events into sticky flags
// (write-1-to-clear) and drives a maskable, registered level interrupt.
// Build option: KEYIN_DEBOUNCE_EN enables the filter, tick counter and the
// PERIOD registers ($5/$6); without it STATE follows the synchronizers.
// Ports:
//   clk_in  clock            rst   synchronous active-high reset
//   AD      register address DI    write data
//   DO      registered read data
//   rw      1=read 0=write   cs    chip select (access every edge with cs=1)
//   irq     level interrupt  keys  asynchronous key inputs
module keyin
  import keyin_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] PERIOD_RST  = 16'd1000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [3:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic [7:0] keys
);

  logic       w_wr;
  logic       w_rd;
  logic       w_tick;
  logic [7:0] w_state;
  logic [7:0] w_events;
  logic [7:0] w_flags_clr;
  logic [7:0] w_ctrl;
  logic [7:0] w_rd_data;

  logic [7:0] r_state_prev;
  logic [7:0] r_flags;
  logic [7:0] r_mask;
  logic [7:0] r_edge_sel;
  logic       r_ien;
  logic       r_irq;

  assign w_wr = cs & ~rw;
  assign w_rd = cs & rw;

`ifdef KEYIN_DEBOUNCE_EN
  logic [15:0] r_period;
  logic [15:0] r_cnt;
  logic        w_period_wr;

  assign w_period_wr = w_wr & ((AD == KEYIN_PERIOD_HI) | (AD == KEYIN_PERIOD_LO));
  assign w_tick      = (r_cnt == r_period);

  // PERIOD registers and shared tick counter; a PERIOD write restarts the count.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_period <= PERIOD_RST;
      r_cnt    <= 16'd0;
    end else begin
      if (w_wr && (AD == KEYIN_PERIOD_HI)) begin
        r_period[15:8] <= DI;
      end
      if (w_wr && (AD == KEYIN_PERIOD_LO)) begin
        r_period[7:0] <= DI;
      end
      if (w_period_wr || w_tick) begin
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end
`else
  logic w_unused_period;
  assign w_unused_period = ^PERIOD_RST;
  assign w_tick          = 1'b1;
`endif

  for (genvar g = 0; g < 8; g++) begin : g_line
    keyin_debounce #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_debounce (
      .clk_in  (clk_in),
      .rst     (rst),
      .i_key   (keys[g]),
      .i_tick  (w_tick),
      .o_state (w_state[g])
    );
  end

  // Events compare STATE against last cycle's STATE, so EDGE writes alone
  // never produce one.
  assign w_events = keyin_edge_events(w_state, r_state_prev, r_edge_sel);

  // Write-1-to-clear mask for FLAGS.
  always_comb begin
    w_flags_clr = 8'h00;
    if (w_wr && (AD == KEYIN_FLAGS)) begin
      w_flags_clr = DI;
    end else begin
      w_flags_clr = 8'h00;
    end
  end

  // Read multiplexer.
  always_comb begin
    w_ctrl                 = 8'h00;
    w_ctrl[KEYIN_CTRL_IRQ] = r_irq;
    w_ctrl[KEYIN_CTRL_IEN] = r_ien;
    w_rd_data              = 8'h00;
    case (AD)
      KEYIN_STATE:     w_rd_data = w_state;
      KEYIN_FLAGS:     w_rd_data = r_flags;
      KEYIN_MASK:      w_rd_data = r_mask;
      KEYIN_EDGE:      w_rd_data = r_edge_sel;
      KEYIN_CTRL:      w_rd_data = w_ctrl;
`ifdef KEYIN_DEBOUNCE_EN
      KEYIN_PERIOD_HI: w_rd_data = r_period[15:8];
      KEYIN_PERIOD_LO: w_rd_data = r_period[7:0];
`endif
      default:         w_rd_data = 8'h00;
    endcase
  end

  // Control registers, sticky flags (set beats clear), irq and read data.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state_prev <= 8'h00;
      r_flags      <= 8'h00;
      r_mask       <= 8'h00;
      r_edge_sel   <= 8'h00;
      r_ien        <= 1'b0;
      r_irq        <= 1'b0;
      DO           <= 8'h00;
    end else begin
      r_state_prev <= w_state;
      r_flags      <= (r_flags & ~w_flags_clr) | w_events;
      r_irq        <= r_ien & (|(r_flags & r_mask));
      if (w_wr) begin
        case (AD)
          KEYIN_MASK: r_mask     <= DI;
          KEYIN_EDGE: r_edge_sel <= DI;
          KEYIN_CTRL: r_ien      <= DI[KEYIN_CTRL_IEN];
          default:    ;
        endcase
      end
      if (w_rd) begin
        DO <= w_rd_data;
      end
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_keyin.sv
// tb_keyin: directed self-checking bench for keyin. Expected timing and
// values are hand-derived for SYNC_STAGES=2 and adapt to KEYIN_DEBOUNCE_EN.
module tb_keyin;

`ifdef KEYIN_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  // Cycles from a keys change (driven at a negedge) to irq / FLAGS update
  // with PERIOD=0: 2 sync + (4 ticks | 1 reg) + 1 flag (+1 irq).
  localparam int FSET    = DB ? 7 : 4;
  localparam int IRQ_LAT = FSET + 1;

  logic       clk_in;
  logic       rst;
  logic [3:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;
  logic [7:0] keys;

  int n_checks;
  int n_fail;

  keyin dut (
    .clk_in (clk_in),
    .rst    (rst),
    .AD     (AD),
    .DI     (DI),
    .DO     (DO),
    .rw     (rw),
    .cs     (cs),
    .irq    (irq),
    .keys   (keys)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Bus tasks are entered at a negedge and return at the following negedge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk_in);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    @(negedge clk_in);
    cs = 1'b0;
    d = DO;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    logic [7:0] d;
    logic       seen;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 4'h0; DI = 8'h00; keys = 8'h00;
    cycles(3);
    rst = 1'b0;

    // Reset state
    check("rst_do", DO, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    rd_chk("rst_state", 4'h0, 8'h00);
    rd_chk("rst_flags", 4'h1, 8'h00);
    rd_chk("rst_mask", 4'h2, 8'h00);
    rd_chk("rst_edge", 4'h3, 8'h00);
    rd_chk("rst_ctrl", 4'h4, 8'h00);
    rd_chk("rst_per_hi", 4'h5, DB ? 8'h03 : 8'h00);
    rd_chk("rst_per_lo", 4'h6, DB ? 8'hE8 : 8'h00);
    rd_chk("rst_unmapped", 4'h9, 8'h00);
    wr(4'h0, 8'hFF);
    rd_chk("state_ro", 4'h0, 8'h00);

    // Rising edge with IRQ, exact latency
    wr(4'h5, 8'h00);
    wr(4'h6, 8'h00);
    wr(4'h2, 8'h01);
    wr(4'h4, 8'h40);
    keys[0] = 1'b1;
    cycles(IRQ_LAT - 1);
    check("rise_irq_early", {7'd0, irq}, 8'h00);
    cycles(1);
    check("rise_irq", {7'd0, irq}, 8'h01);
    rd_chk("rise_state", 4'h0, 8'h01);
    rd_chk("rise_flags", 4'h1, 8'h01);
    rd_chk("rise_ctrl", 4'h4, 8'hC0);
    wr(4'h1, 8'h01);
    cycles(1);
    check("w1c_irq", {7'd0, irq}, 8'h00);
    rd_chk("w1c_flags", 4'h1, 8'h00);

    // Bounce rejection
    wr(4'h1, 8'hFF);
`ifdef KEYIN_DEBOUNCE_EN
    wr(4'h6, 8'h09);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      keys[3] = ~keys[3];
      cycles(13);
      rd(4'h0, d);
      seen = seen | d[3];
    end
    check("bounce_hold", {7'd0, seen}, 8'h00);
    rd_chk("bounce_flags", 4'h1, 8'h00);
    keys[3] = 1'b1;
    cycles(20);
    rd_chk("bounce_not_yet", 4'h0, 8'h01);
    cycles(30);
    rd_chk("bounce_state", 4'h0, 8'h09);
    rd_chk("bounce_flag", 4'h1, 8'h08);
    wr(4'h6, 8'h00);
`else
    wr(4'h5, 8'hFF);
    rd_chk("per_absent", 4'h5, 8'h00);
    keys[3] = 1'b1;
    cycles(6);
    rd_chk("bounce_state", 4'h0, 8'h09);
    rd_chk("bounce_flag", 4'h1, 8'h08);
`endif

    // Falling edge select
    wr(4'h1, 8'hFF);
    wr(4'h3, 8'h80);
    rd_chk("edge_rb", 4'h3, 8'h80);
    keys[7] = 1'b1;
    cycles(60);
    rd_chk("fall_state_hi", 4'h0, 8'h89);
    rd_chk("fall_no_flag", 4'h1, 8'h00);
    keys[7] = 1'b0;
    cycles(60);
    rd_chk("fall_state_lo", 4'h0, 8'h09);
    rd_chk("fall_flag", 4'h1, 8'h80);

    // Set/clear collision on FLAGS[2]
    wr(4'h1, 8'hFF);
    keys[2] = 1'b1;
    cycles(FSET - 1);
    wr(4'h1, 8'h04);
    rd_chk("collide_flags", 4'h1, 8'h04);
    rd_chk("collide_state", 4'h0, 8'h0D);
    wr(4'h1, 8'h04);
    rd_chk("clear_after", 4'h1, 8'h00);

    // Masking
    wr(4'h2, 8'h00);
    keys[4] = 1'b1;
    cycles(60);
    rd_chk("mask_flags", 4'h1, 8'h10);
    check("mask_irq_off", {7'd0, irq}, 8'h00);
    wr(4'h2, 8'h10);
    check("mask_irq_lat", {7'd0, irq}, 8'h00);
    cycles(1);
    check("mask_irq_on", {7'd0, irq}, 8'h01);
    wr(4'h4, 8'h00);
    cycles(1);
    check("ien_off_irq", {7'd0, irq}, 8'h00);

    // Keys held high through reset appear as rising edges once debounced
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    rd_chk("rst2_state", 4'h0, 8'h00);
    rd_chk("rst2_flags", 4'h1, 8'h00);
    cycles(DB ? 4100 : 10);
    rd_chk("rst2_state_db", 4'h0, 8'h1D);
    rd_chk("rst2_flags_db", 4'h1, 8'h1D);
    check("rst2_irq", {7'd0, irq}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
